// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every handshake and data signal around dmem_arbiter: the two
// requester ports (port 0 = core load/store unit, port 1 = DMA/debug loader),
// the shared response path, and the single data-memory port.
//
// Signal names keep their direction suffix as seen from the arbiter.
//   req_valid_i/req_wen_i/req_byte_i [1:0]  per-port request qualifiers
//   req_addr_i  [2*addr_width_p]            port n at [n*addr_width_p +: addr_width_p]
//   req_wdata_i [2*data_width_p]            port n at [n*data_width_p +: data_width_p]
//   req_yumi_o  [1:0]                       request accepted (one-hot or zero)
//   rsp_valid_o [1:0], rsp_rdata_o          response to the owning port
//   rsp_yumi_i  [1:0]                       response consumed by requester
//   mem_valid_o/mem_wen_o/mem_byte_o, mem_addr_o, mem_wdata_o, mem_yumi_i
//                                           request path to memory
//   mem_valid_i, mem_rdata_i, mem_yumi_o    response path from memory
//
// Modports:
//   slave  - the arbiter itself (it serves the requesters)
//   master - the surrounding environment (requesters + memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic [1:0]                  req_valid_i;
    logic [1:0]                  req_wen_i;
    logic [1:0]                  req_byte_i;
    logic [2*addr_width_p-1:0]   req_addr_i;
    logic [2*data_width_p-1:0]   req_wdata_i;
    logic [1:0]                  req_yumi_o;

    logic [1:0]                  rsp_valid_o;
    logic [data_width_p-1:0]     rsp_rdata_o;
    logic [1:0]                  rsp_yumi_i;

    logic                        mem_valid_o;
    logic                        mem_wen_o;
    logic                        mem_byte_o;
    logic [addr_width_p-1:0]     mem_addr_o;
    logic [data_width_p-1:0]     mem_wdata_o;
    logic                        mem_yumi_i;

    logic                        mem_valid_i;
    logic [data_width_p-1:0]     mem_rdata_i;
    logic                        mem_yumi_o;

    modport slave (
        input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i,
        output req_yumi_o,
        output rsp_valid_o, rsp_rdata_o,
        input  rsp_yumi_i,
        output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
        input  mem_yumi_i,
        input  mem_valid_i, mem_rdata_i,
        output mem_yumi_o
    );

    modport master (
        output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i,
        input  req_yumi_o,
        input  rsp_valid_o, rsp_rdata_o,
        output rsp_yumi_i,
        input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
        output mem_yumi_i,
        output mem_valid_i, mem_rdata_i,
        input  mem_yumi_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester round-robin arbiter in front of a single data-memory port.
// One transaction is outstanding at a time; the granted request passes to
// memory combinationally (no added latency), and the memory response is routed
// back to the port that owns the transaction.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   bus          dmem_arbiter_if.slave: requester, response and memory signals
//   grant_cnt_o  [31:0] per-port retired-transaction counters, port n at
//                [n*16 +: 16], saturating (only with DMEM_ARB_STATS_EN)
//
// Configuration:
//   DMEM_ARB_STATS_EN  when defined, adds grant_cnt_o and its counters.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32
) (
    input  logic               clk,
    input  logic               reset,
    dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [2*16-1:0]    grant_cnt_o
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e r_state;
    logic   r_owner;   // port that owns the outstanding transaction
    logic   r_prio;    // port that wins a tie

    state_e w_state_nxt;
    logic   w_owner_nxt;
    logic   w_prio_nxt;

    logic       w_any_valid;
    logic       w_winner;
    logic       w_retire;
    logic [1:0] w_req_yumi;
    logic [1:0] w_rsp_valid;
    logic       w_mem_valid;
    logic       w_mem_yumi;

    // Tie goes to r_prio; otherwise the single requesting port wins.
    assign w_any_valid = |bus.req_valid_i;
    assign w_winner    = (&bus.req_valid_i) ? r_prio : bus.req_valid_i[1];

    // Response handed over to the owner; this retires the transaction.
    assign w_retire = (r_state == ST_BUSY) && bus.mem_valid_i && bus.rsp_yumi_i[r_owner];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no inferred latch).
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        w_req_yumi  = 2'b00;
        w_rsp_valid = 2'b00;
        w_mem_valid = 1'b0;
        w_mem_yumi  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_mem_valid           = 1'b1;
                    w_req_yumi[w_winner]  = bus.mem_yumi_i;
                    if (bus.mem_yumi_i) begin
                        w_state_nxt = ST_BUSY;
                        w_owner_nxt = w_winner;
                    end
                end
            end
            ST_BUSY: begin
                // New requests stay pending; only the owner sees the response.
                w_rsp_valid[r_owner] = bus.mem_valid_i;
                w_mem_yumi           = w_retire;
                if (w_retire) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = ~r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are held low for as long as reset is asserted.
    assign bus.req_yumi_o  = reset ? w_req_yumi  : 2'b00;
    assign bus.rsp_valid_o = reset ? w_rsp_valid : 2'b00;
    assign bus.mem_valid_o = reset ? w_mem_valid : 1'b0;
    assign bus.mem_yumi_o  = reset ? w_mem_yumi  : 1'b0;

    // Winner's request fields go straight to memory.
    assign bus.mem_wen_o   = bus.req_wen_i[w_winner];
    assign bus.mem_byte_o  = bus.req_byte_i[w_winner];
    assign bus.mem_addr_o  = w_winner ? bus.req_addr_i[2*addr_width_p-1:addr_width_p]
                                      : bus.req_addr_i[addr_width_p-1:0];
    assign bus.mem_wdata_o = w_winner ? bus.req_wdata_i[2*data_width_p-1:data_width_p]
                                      : bus.req_wdata_i[data_width_p-1:0];

    assign bus.rsp_rdata_o = bus.mem_rdata_i;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_grant_cnt [2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant_cnt[0] <= '0;
            r_grant_cnt[1] <= '0;
        end else if (w_retire && (r_grant_cnt[r_owner] != 16'hFFFF)) begin
            r_grant_cnt[r_owner] <= r_grant_cnt[r_owner] + 16'd1;
        end
    end

    assign grant_cnt_o = {r_grant_cnt[1], r_grant_cnt[0]};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Requests are queued per port and presented
// by a driver; on acceptance the expected response is pushed to a scoreboard
// that a negedge monitor pops when the DUT hands a response to a requester.
// A small memory model accepts requests when mem_accept is set and answers
// the cycle after acceptance from a fixed read-only content map.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        wen;
        logic        is_byte;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } req_t;

    typedef struct {
        int          port;
        logic        is_write;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    dmem_arbiter #(.data_width_p(DW), .addr_width_p(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    req_t req_q0[$];
    req_t req_q1[$];
    exp_t sb[$];
    int   grant_log[$];
    int   checks = 0;
    int   errors = 0;

    logic       mem_accept;
    logic [1:0] rsp_accept;
    logic       mem_pending;
    logic [31:0] pend_rdata;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory contents: two named words, everything else {C0DE, addr[15:0]}.
    function automatic logic [31:0] rom(logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h30:  return 32'h30303030;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign bus.mem_yumi_i  = bus.mem_valid_o & mem_accept;
    assign bus.rsp_yumi_i  = rsp_accept;
    assign bus.mem_valid_i = mem_pending;
    assign bus.mem_rdata_i = pend_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_pending <= 1'b0;
            pend_rdata  <= '0;
        end else if (bus.mem_valid_o && bus.mem_yumi_i) begin
            mem_pending <= 1'b1;
            pend_rdata  <= rom(bus.mem_addr_o);
        end else if (bus.mem_yumi_o) begin
            mem_pending <= 1'b0;
        end
    end

    // Driver: present the head of each port queue just after every posedge.
    task automatic present();
        logic [1:0] v;
        v = 2'b00;
        bus.req_wen_i   = 2'b00;
        bus.req_byte_i  = 2'b00;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        if (req_q0.size() > 0) begin
            v[0] = 1'b1;
            bus.req_wen_i[0]         = req_q0[0].wen;
            bus.req_byte_i[0]        = req_q0[0].is_byte;
            bus.req_addr_i[AW-1:0]   = req_q0[0].addr;
            bus.req_wdata_i[DW-1:0]  = req_q0[0].wdata;
        end
        if (req_q1.size() > 0) begin
            v[1] = 1'b1;
            bus.req_wen_i[1]           = req_q1[0].wen;
            bus.req_byte_i[1]          = req_q1[0].is_byte;
            bus.req_addr_i[2*AW-1:AW]  = req_q1[0].addr;
            bus.req_wdata_i[2*DW-1:DW] = req_q1[0].wdata;
        end
        bus.req_valid_i = v;
    endtask

    initial begin : driver
        present();
        forever begin
            @(posedge clk);
            #1;
            present();
        end
    end

    // Monitor/scoreboard: retire responses, then log acceptances.
    task automatic monitor();
        logic [1:0] hs;
        exp_t       e;
        req_t       r;
        if (reset !== 1'b1) return;
        hs = bus.rsp_valid_o & bus.rsp_yumi_i;
        if (hs != 2'b00) begin
            check("rsp_onehot", 64'($onehot(hs)), 64'd1);
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(hs), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_port", 64'(hs), 64'(2'b01 << e.port));
                if (!e.is_write) check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e.rdata));
                check("rsp_mem_yumi", 64'(bus.mem_yumi_o), 64'd1);
            end
        end
        if (bus.req_yumi_o != 2'b00) begin
            check("req_yumi_onehot", 64'($onehot(bus.req_yumi_o)), 64'd1);
            for (int p = 0; p < 2; p++) begin
                if (bus.req_yumi_o[p]) begin
                    if ((p == 0 ? req_q0.size() : req_q1.size()) == 0) begin
                        check("yumi_unrequested", 64'(p), 64'd99);
                    end else begin
                        r = (p == 0) ? req_q0.pop_front() : req_q1.pop_front();
                        e.port = p;
                        e.is_write = r.wen;
                        e.rdata = r.exp_rdata;
                        sb.push_back(e);
                        grant_log.push_back(p);
                    end
                end
            end
        end
    endtask

    initial begin : mon
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Control inputs change at posedge+2; checks run at negedge+1.
    task automatic at_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(int p, logic wen, logic is_byte, logic [31:0] addr,
                            logic [31:0] wdata, logic [31:0] exp_rdata);
        req_t r;
        r.wen = wen; r.is_byte = is_byte; r.addr = addr;
        r.wdata = wdata; r.exp_rdata = exp_rdata;
        if (p == 0) req_q0.push_back(r);
        else        req_q1.push_back(r);
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while ((req_q0.size() + req_q1.size() + sb.size()) != 0 && n < 300) begin
            at_sample();
            n++;
        end
        check({name, "_drain"}, 64'(n < 300), 64'd1);
        at_sample();
    endtask

    task automatic check_outputs_zero(string name);
        check({name, "_req_yumi"},  64'(bus.req_yumi_o),  64'd0);
        check({name, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check({name, "_mem_valid"}, 64'(bus.mem_valid_o), 64'd0);
        check({name, "_mem_yumi"},  64'(bus.mem_yumi_o),  64'd0);
    endtask

    initial begin : main
        int t2_order[6] = '{0, 1, 0, 1, 0, 1};
        int t5_order[2] = '{0, 1};

        reset      = 1'b0;
        mem_accept = 1'b1;
        rsp_accept = 2'b11;

        // Reset state with a request already pending on port 0.
        push_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        repeat (3) at_sample();
        check_outputs_zero("reset");
`ifdef DMEM_ARB_STATS_EN
        check("reset_grant_cnt", 64'(grant_cnt), 64'd0);
`endif

        // Port 0 word read of 0x10: accepted in cycle 0, response in cycle 1.
        at_drive();
        reset = 1'b1;
        at_sample();
        check("t1_req_yumi",  64'(bus.req_yumi_o),  64'b01);
        check("t1_mem_valid", 64'(bus.mem_valid_o), 64'd1);
        check("t1_mem_addr",  64'(bus.mem_addr_o),  64'h10);
        check("t1_mem_wen",   64'(bus.mem_wen_o),   64'd0);
        at_sample();
        check("t1_rsp_valid", 64'(bus.rsp_valid_o), 64'b01);
        check("t1_rsp_rdata", 64'(bus.rsp_rdata_o), 64'hDEADBEEF);
        check("t1_mem_yumi",  64'(bus.mem_yumi_o),  64'd1);
        wait_drain("t1");

        // After port 0 retired, port 1 wins a tie; held while memory stalls.
        at_drive();
        mem_accept = 1'b0;
        grant_log.delete();
        push_req(0, 1'b1, 1'b0, 32'h20, 32'h11111111, 32'h0);
        push_req(1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h30303030);
        at_sample();
        at_sample();
        repeat (3) begin
            check("t1b_tie_addr",  64'(bus.mem_addr_o),  64'h30);
            check("t1b_stall_yumi", 64'(bus.req_yumi_o), 64'd0);
            at_sample();
        end
        at_drive();
        mem_accept = 1'b1;
        wait_drain("t1b");
        check("t1b_log_size", 64'(grant_log.size()), 64'd2);
        for (int i = 0; i < 2; i++)
            check("t1b_grant_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(1 - i));

        // Both ports requesting from reset: grants alternate 0,1,0,1,...
        at_drive();
        reset = 1'b0;
        grant_log.delete();
        push_req(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hC0DE0100);
        push_req(0, 1'b0, 1'b0, 32'h104, 32'h0, 32'hC0DE0104);
        push_req(0, 1'b0, 1'b0, 32'h108, 32'h0, 32'hC0DE0108);
        push_req(1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hC0DE0200);
        push_req(1, 1'b0, 1'b0, 32'h204, 32'h0, 32'hC0DE0204);
        push_req(1, 1'b0, 1'b0, 32'h208, 32'h0, 32'hC0DE0208);
        at_sample();
        at_sample();
        at_drive();
        reset = 1'b1;
        wait_drain("t2");
        check("t2_log_size", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check("t2_grant_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(t2_order[i]));

        // Port 1 byte write of 0xA5 to 0x7.
        at_drive();
        mem_accept = 1'b0;
        push_req(1, 1'b1, 1'b1, 32'h7, 32'h000000A5, 32'h0);
        at_sample();
        at_sample();
        check("t3_mem_valid", 64'(bus.mem_valid_o),      64'd1);
        check("t3_mem_wen",   64'(bus.mem_wen_o),        64'd1);
        check("t3_mem_byte",  64'(bus.mem_byte_o),       64'd1);
        check("t3_mem_addr",  64'(bus.mem_addr_o),       64'h7);
        check("t3_mem_wdata", 64'(bus.mem_wdata_o[7:0]), 64'hA5);
        at_drive();
        mem_accept = 1'b1;
        wait_drain("t3");

        // Owner holds its response for 3 cycles; only a non-owner yumi is high.
        at_drive();
        rsp_accept = 2'b10;
        push_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        at_sample();
        at_sample();
        check("t4_req_yumi", 64'(bus.req_yumi_o), 64'b01);
        push_req(1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h30303030);
        repeat (3) begin
            at_sample();
            check("t4_hold_rsp_valid", 64'(bus.rsp_valid_o), 64'b01);
            check("t4_hold_mem_yumi",  64'(bus.mem_yumi_o),  64'd0);
            check("t4_hold_req_yumi",  64'(bus.req_yumi_o),  64'd0);
        end
        at_drive();
        rsp_accept = 2'b11;
        at_sample();
        check("t4_retire_mem_yumi", 64'(bus.mem_yumi_o), 64'd1);
        check("t4_retire_req_yumi", 64'(bus.req_yumi_o), 64'd0);
        at_sample();
        check("t4_next_grant", 64'(bus.req_yumi_o), 64'b10);
        wait_drain("t4");

        // Reset while BUSY abandons the transaction.
        at_drive();
        rsp_accept = 2'b00;
        push_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        at_sample();
        at_sample();
        check("t5_req_yumi", 64'(bus.req_yumi_o), 64'b01);
        at_sample();
        check("t5_busy_rsp_valid", 64'(bus.rsp_valid_o), 64'b01);
        at_drive();
        reset = 1'b0;
        at_sample();
        check_outputs_zero("t5_in_reset");
        sb.delete();
        at_drive();
        at_sample();
        check_outputs_zero("t5_after_edge");
`ifdef DMEM_ARB_STATS_EN
        check("t5_grant_cnt", 64'(grant_cnt), 64'd0);
`endif
        at_drive();
        reset      = 1'b1;
        rsp_accept = 2'b11;
        mem_accept = 1'b0;
        grant_log.delete();
        push_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        push_req(1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h30303030);
        at_sample();
        check("t5_no_stale_rsp", 64'(bus.rsp_valid_o), 64'd0);
        at_sample();
        check("t5_idle_mem_valid", 64'(bus.mem_valid_o), 64'd1);
        check("t5_prio0_addr",     64'(bus.mem_addr_o),  64'h10);
        at_drive();
        mem_accept = 1'b1;
        wait_drain("t5");
        check("t5_log_size", 64'(grant_log.size()), 64'd2);
        for (int i = 0; i < 2; i++)
            check("t5_grant_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(t5_order[i]));

`ifdef DMEM_ARB_STATS_EN
        // 5 transactions on port 0 and 3 on port 1 after a fresh reset.
        at_drive();
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            push_req(0, 1'b0, 1'b0, 32'h100 + 32'(4*i), 32'h0, 32'hC0DE0100 + 32'(4*i));
        for (int i = 0; i < 3; i++)
            push_req(1, 1'b0, 1'b0, 32'h200 + 32'(4*i), 32'h0, 32'hC0DE0200 + 32'(4*i));
        at_sample();
        at_sample();
        check("stats_cleared", 64'(grant_cnt), 64'd0);
        at_drive();
        reset = 1'b1;
        wait_drain("stats");
        check("stats_counts", 64'(grant_cnt), 64'({16'd3, 16'd5}));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single data memory port.
- Lets the core load/store unit (port 0) and a secondary master such as a DMA or debug loader (port 1) share one memory.
- Uses the same valid/yumi request-response handshake on every side.
- Round-robin grant, one outstanding transaction at a time, zero added latency on the granted path.

Parameters:
- data_width_p, 32, width of write/read data.
- addr_width_p, 32, width of request address.

Ports:
- clk  input  1  clock; reset is synchronous, active-low on rising clk.
- reset  input  1  active-low synchronous reset.
- req_valid_i  input  2  per-port request valid.
- req_wen_i  input  2  per-port write enable.
- req_byte_i  input  2  per-port byte_not_word.
- req_addr_i  input  2*addr_width_p  per-port address; port n occupies bits [n*addr_width_p +: addr_width_p].
- req_wdata_i  input  2*data_width_p  per-port write data.
- req_yumi_o  output  2  request accepted, one-hot or zero.
- rsp_valid_o  output  2  response valid, one-hot or zero.
- rsp_rdata_o  output  data_width_p  response read data, shared by both ports.
- rsp_yumi_i  input  2  per-port response consumed.
- mem_valid_o, mem_wen_o, mem_byte_o  output  1 each  request to memory.
- mem_addr_o  output  addr_width_p  address to memory.
- mem_wdata_o  output  data_width_p  write data to memory.
- mem_yumi_i  input  1  memory accepted request.
- mem_valid_i  input  1  memory response valid.
- mem_rdata_i  input  data_width_p  memory read data.
- mem_yumi_o  output  1  response consumed, to memory.

Behaviour:
- State machine: IDLE, BUSY. Registers: state_r, owner_r (1 bit), prio_r (1 bit, port with priority).
- Reset (reset==0 at posedge): state_r=IDLE, owner_r=0, prio_r=0.
- While reset==0 all outputs are forced to 0: req_yumi_o, rsp_valid_o, mem_valid_o, mem_yumi_o.
- Reset mid-transaction abandons it; no response is delivered afterwards.
- IDLE, grant selection (combinational):
  - Only one port valid: that port wins.
  - Both ports valid: prio_r wins.
  - Winner's wen/byte/addr/wdata drive the mem_* outputs; mem_valid_o=1.
- IDLE, acceptance:
  - req_yumi_o[winner]=mem_yumi_i in the same cycle. The loser gets yumi 0 and must hold its request.
  - If mem_yumi_i is high: owner_r<=winner, state_r<=BUSY. Otherwise remain in IDLE and re-arbitrate next cycle.
- BUSY:
  - mem_valid_o=0; req_yumi_o=0 for both ports; new requests are ignored but stay pending.
  - rsp_valid_o[owner_r]=mem_valid_i and rsp_rdata_o=mem_rdata_i. The non-owner bit is 0.
  - mem_yumi_o=rsp_yumi_i[owner_r] & mem_valid_i. Non-owner rsp_yumi_i is ignored.
  - When mem_valid_i & rsp_yumi_i[owner_r]: state_r<=IDLE, prio_r<=~owner_r.
- rsp_rdata_o is don't-care when no rsp_valid_o bit is set, and for writes.
- Throughput: next grant no earlier than the cycle after response retirement, i.e. at most one transaction per 2 cycles.
- Arbitration never changes while a request is waiting in IDLE with mem_yumi_i low.
- Starvation-free: after port n completes, port ~n wins the next tie.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds output grant_cnt_o (2*16 bits): per-port count of completed transactions.
  - Incremented on retirement (mem_valid_i & rsp_yumi_i[owner_r] in BUSY).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined, the port and its counters do not exist; all other behaviour is identical.

Test Plan:
- Port 0 only, read of word at 0x10 returning 0xDEADBEEF, memory yumi=valid:
  - req_yumi_o=01 at cycle 0.
  - rsp_valid_o=01 with rsp_rdata_o=0xDEADBEEF at cycle 1.
  - rsp_yumi_i=01 returns state to IDLE; prio_r=1.
- Both ports valid from reset:
  - Port 0 is granted first, then port 1, then port 0.
  - Grants alternate each transaction and req_yumi_o is never 11.
- Port 1 write 0xA5 byte to 0x7 while port 0 idle:
  - mem_wen_o=1, mem_byte_o=1, mem_addr_o=0x7, mem_wdata_o[7:0]=0xA5.
  - Response retired via rsp_yumi_i[1].
- Owner delays rsp_yumi_i for 3 cycles:
  - rsp_valid_o stays high each cycle and mem_yumi_o stays 0.
  - Port 1 valid during this window gets no yumi.
  - Port 1 is granted the cycle after retirement.
- Reset asserted in BUSY:
  - Next cycle all outputs are 0, state is IDLE, prio_r=0.
  - With DMEM_ARB_STATS_EN, grant_cnt_o=0.
- With DMEM_ARB_STATS_EN, 5 transactions on port 0 and 3 on port 1 -> grant_cnt_o = {16'd3, 16'd5}.
